// File: rtl/ft_packet_pkg.sv
// Shared definitions for the FT telemetry framing paths (host<->FPGA).
// Word order and packet width are common to serializer and deframer.
package ft_packet_pkg;

    localparam int          PKT_W         = 88;
    localparam int          WORDS_PER_PKT = 6;
    localparam logic [15:0] DEFAULT_SYNC  = 16'hA55A;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        EMIT
    } state_e;

    // Word idx lands on bits [16*idx+15 : 16*idx]; the last word only has a byte.
    function automatic logic [PKT_W-1:0] place_word(
        input logic [PKT_W-1:0] pkt,
        input logic [2:0]       idx,
        input logic [15:0]      word
    );
        logic [PKT_W-1:0] r;
        r = pkt;
        unique case (idx)
            3'd0:    r[15:0]  = word;
            3'd1:    r[31:16] = word;
            3'd2:    r[47:32] = word;
            3'd3:    r[63:48] = word;
            3'd4:    r[79:64] = word;
            3'd5:    r[87:80] = word[7:0];
            default: r        = pkt;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ft_packet_deframer_sat_counter.sv
// Event counter with synchronous clear; SAT selects hold-at-max versus wrap.
// Clear wins over a same-cycle increment.
module sat_counter
    import ft_packet_pkg::*;
#(
    parameter int W   = 16,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic         full;

    assign full  = SAT && (&cnt_q);
    assign cnt_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !full) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/ft_packet_deframer.sv
// Host-to-FPGA deframer: sync hunt, 6-word packet reassembly, error counting.
// Define FT_DEFRAME_CHECKSUM_EN to require a trailing XOR checksum word.
module ft_packet_deframer
    import ft_packet_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD      = DEFAULT_SYNC,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter int          CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      ui_dout,
    input  logic [1:0]       ui_dout_be,
    input  logic             ui_dout_empty,
    output logic             ui_dout_get,
    input  logic             clear_counters,
    output logic [PKT_W-1:0] packet_data,
    output logic             packet_valid,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             frame_busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    logic [2:0]       idx_q;
    logic [TW-1:0]    to_q;
    logic [PKT_W-1:0] shadow_q;
    logic [PKT_W-1:0] pkt_q;
    logic             valid_q;
    logic             get_q;
    logic             busy_q;

    logic accept;
    logic last_data;
    logic be_ok;
    logic frame_ok;
    logic frame_err;

`ifdef FT_DEFRAME_CHECKSUM_EN
    logic [15:0] csum_q;
    logic [15:0] word_m;
    assign word_m = last_data ? {8'h00, ui_dout[7:0]} : ui_dout;
`endif

    always_comb begin
        accept    = get_q && !ui_dout_empty;
        last_data = (idx_q == 3'(WORDS_PER_PKT - 1));
        be_ok     = last_data ? ui_dout_be[0] : (ui_dout_be == 2'b11);
        frame_ok  = 1'b0;
        frame_err = (state_q == DATA) && !accept
                    && (to_q == TW'(TIMEOUT_CYCLES - 1));
        if (state_q == DATA && accept) begin
`ifdef FT_DEFRAME_CHECKSUM_EN
            if (idx_q == 3'(WORDS_PER_PKT)) begin
                if (ui_dout_be == 2'b11 && ui_dout == csum_q) begin
                    frame_ok = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end else if (!be_ok) begin
                frame_err = 1'b1;
            end
`else
            if (!be_ok) begin
                frame_err = 1'b1;
            end else if (last_data) begin
                frame_ok = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (accept && ui_dout == SYNC_WORD && ui_dout_be == 2'b11) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (frame_err) begin
                    state_d = HUNT;
                end else if (frame_ok) begin
                    state_d = EMIT;
                end
            end
            EMIT:    state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            idx_q    <= '0;
            to_q     <= '0;
            shadow_q <= '0;
            pkt_q    <= '0;
            valid_q  <= 1'b0;
            get_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FT_DEFRAME_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            get_q   <= (state_d != EMIT);
            busy_q  <= (state_d == DATA);
            valid_q <= frame_ok;
            unique case (state_q)
                HUNT: begin
                    idx_q  <= '0;
                    to_q   <= '0;
`ifdef FT_DEFRAME_CHECKSUM_EN
                    csum_q <= '0;
`endif
                end
                DATA: begin
                    if (frame_ok) begin
`ifdef FT_DEFRAME_CHECKSUM_EN
                        pkt_q <= shadow_q;
`else
                        pkt_q <= place_word(shadow_q, idx_q, ui_dout);
`endif
                    end else if (!frame_err) begin
                        if (accept) begin
                            shadow_q <= place_word(shadow_q, idx_q, ui_dout);
                            idx_q    <= idx_q + 3'd1;
                            to_q     <= '0;
`ifdef FT_DEFRAME_CHECKSUM_EN
                            csum_q   <= csum_q ^ word_m;
`endif
                        end else begin
                            to_q <= to_q + TW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter #(.W(CNT_W), .SAT(1'b0)) u_pkt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (frame_ok),
        .clr_i (clear_counters),
        .cnt_o (pkt_count)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (frame_err),
        .clr_i (clear_counters),
        .cnt_o (err_count)
    );

    assign ui_dout_get  = get_q;
    assign packet_data  = pkt_q;
    assign packet_valid = valid_q;
    assign frame_busy   = busy_q;

endmodule

// File: tb/tb_ft_packet_deframer.sv
// Directed + randomized bench for ft_packet_deframer against a packet-level model.
// Narrow counters (CNT_W=4) make wrap and saturation reachable quickly.
module tb_ft_packet_deframer;

    localparam int          CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
    localparam logic [15:0] SYNC = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ui_dout = '0;
    logic [1:0]  ui_dout_be = '0;
    logic        ui_dout_empty = 1'b1;
    logic        ui_dout_get;
    logic        clear_counters = 1'b0;
    logic [87:0] packet_data;
    logic        packet_valid;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] err_count;
    logic        frame_busy;

    int checks = 0;
    int failures = 0;
    int vcount = 0;
    int exp_vcount = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    logic [87:0] exp_data = '0;

    always #5 clk = ~clk;

    ft_packet_deframer #(
        .SYNC_WORD(SYNC), .TIMEOUT_CYCLES(1024), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ui_dout(ui_dout), .ui_dout_be(ui_dout_be),
        .ui_dout_empty(ui_dout_empty), .ui_dout_get(ui_dout_get),
        .clear_counters(clear_counters),
        .packet_data(packet_data), .packet_valid(packet_valid),
        .pkt_count(pkt_count), .err_count(err_count),
        .frame_busy(frame_busy)
    );

    always @(negedge clk) if (packet_valid === 1'b1) vcount++;

    task automatic check(input string tag, input logic [87:0] obs,
                         input logic [87:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] model_pkt(input logic [5:0][15:0] w);
        return {w[5][7:0], w[4], w[3], w[2], w[1], w[0]};
    endfunction

    function automatic logic [15:0] model_csum(input logic [5:0][15:0] w);
        logic [15:0] r;
        r = {8'h00, w[5][7:0]};
        for (int i = 0; i < 5; i++) r ^= w[i];
        return r;
    endfunction

    function automatic logic [5:0][15:0] rand_words();
        logic [5:0][15:0] w;
        for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
        return w;
    endfunction

    task automatic model_good();
        exp_pkt = (exp_pkt + 1) % (CMAX + 1);
        exp_vcount++;
    endtask

    task automatic model_bad();
        if (exp_err < CMAX) exp_err++;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_pkt"}, 88'(pkt_count), 88'(exp_pkt));
        check({tag, "_err"}, 88'(err_count), 88'(exp_err));
    endtask

    task automatic send_word(input logic [15:0] w, input logic [1:0] be,
                             input bit clr, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        ui_dout = w;
        ui_dout_be = be;
        ui_dout_empty = 1'b0;
        clear_counters = clr;
        while (ui_dout_get !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("get_wait", 88'(n < 8), 88'(1));
        @(posedge clk);
        #1;
        ui_dout_empty = 1'b1;
        clear_counters = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0][15:0] w, input logic [1:0] be5,
                              input bit corrupt, input bit clr, input int maxgap);
        bit ok;
        logic [15:0] cs;
        send_word(SYNC, 2'b11, 1'b0, $urandom_range(0, maxgap));
        for (int i = 0; i < 5; i++)
            send_word(w[i], 2'b11, 1'b0, $urandom_range(0, maxgap));
`ifdef FT_DEFRAME_CHECKSUM_EN
        send_word(w[5], be5, 1'b0, $urandom_range(0, maxgap));
        cs = model_csum(w);
        if (corrupt) cs ^= 16'(1) << $urandom_range(0, 15);
        send_word(cs, 2'b11, clr, $urandom_range(0, maxgap));
        ok = !corrupt;
`else
        cs = model_csum(w);
        send_word(w[5], be5, clr, $urandom_range(0, maxgap));
        ok = !corrupt || (cs != cs);
`endif
        if (ok) begin
            model_good();
            exp_data = model_pkt(w);
        end else begin
            model_bad();
        end
        if (clr) begin
            exp_pkt = 0;
            exp_err = 0;
        end
        check("valid_pulse", 88'(packet_valid), 88'(ok));
        check("packet_data", packet_data, exp_data);
        check_counts("frame");
        @(posedge clk);
        #1;
        check("valid_width", 88'(packet_valid), 88'(0));
    endtask

    task automatic send_be_err(input int k, input logic [1:0] badbe);
        send_word(SYNC, 2'b11, 1'b0, 0);
        for (int i = 0; i < k; i++) send_word(16'($urandom), 2'b11, 1'b0, 0);
        send_word(16'($urandom), badbe, 1'b0, 0);
        model_bad();
        check("be_err_valid", 88'(packet_valid), 88'(0));
        check("be_err_busy", 88'(frame_busy), 88'(0));
        check("be_err_data", packet_data, exp_data);
        check_counts("be_err");
    endtask

    task automatic send_garbage();
        logic [15:0] g;
        logic [1:0]  gbe;
        g = 16'($urandom);
        gbe = 2'($urandom);
        if (g == SYNC && gbe == 2'b11) gbe = 2'b01;
        send_word(g, gbe, 1'b0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_get"}, 88'(ui_dout_get), 88'(0));
        check({tag, "_valid"}, 88'(packet_valid), 88'(0));
        check({tag, "_data"}, packet_data, 88'(0));
        check({tag, "_pkt"}, 88'(pkt_count), 88'(0));
        check({tag, "_err"}, 88'(err_count), 88'(0));
        check({tag, "_busy"}, 88'(frame_busy), 88'(0));
    endtask

    initial begin
        logic [5:0][15:0] w;
        logic [1:0] be5;
        int k;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed reference frame
        w = {16'h0066, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        send_frame(w, 2'b11, 1'b0, 1'b0, 0);
        check("t1_literal", packet_data, 88'h66_5555_4444_3333_2222_1111);

        // Garbage ahead of a frame is dropped silently
        send_word(16'h0000, 2'b11, 1'b0, 0);
        send_word(16'hBEEF, 2'b11, 1'b0, 0);
        send_frame(rand_words(), 2'b11, 1'b0, 1'b0, 0);

        // Bad byte enable mid-frame, then recovery
        send_be_err(2, 2'b10);
        send_frame(rand_words(), 2'b01, 1'b0, 1'b0, 1);

        // Idle timeout boundary
        send_word(SYNC, 2'b11, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_word(16'($urandom), 2'b11, 1'b0, 0);
        repeat (1023) @(posedge clk);
        #1;
        check("to_busy_1023", 88'(frame_busy), 88'(1));
        check("to_err_1023", 88'(err_count), 88'(exp_err));
        @(posedge clk);
        #1;
        model_bad();
        check("to_busy_1024", 88'(frame_busy), 88'(0));
        check_counts("timeout");
        check("to_data", packet_data, exp_data);
        send_frame(rand_words(), 2'b11, 1'b0, 1'b0, 0);

`ifdef FT_DEFRAME_CHECKSUM_EN
        send_frame(w, 2'b11, 1'b1, 1'b0, 0);
        send_frame(w, 2'b11, 1'b0, 1'b0, 0);
`endif

        // Randomized traffic, including errors and last-word be variants
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(0, 3)) send_garbage();
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, 5);
                be5 = (k == 5) ? {1'($urandom), 1'b0} : 2'($urandom_range(0, 2));
                send_be_err(k, be5);
            end else begin
                be5 = $urandom_range(0, 1) ? 2'b11 : 2'b01;
                send_frame(rand_words(), be5, 1'b0, 1'b0, 2);
            end
        end

        // Clear coincident with a packet increment
        send_frame(rand_words(), 2'b11, 1'b0, 1'b1, 0);

        // Error counter saturation
        for (int e = 0; e < CMAX + 2; e++) send_be_err(e % 5, 2'b01);
        check("err_sat", 88'(err_count), 88'(CMAX));

        // Asynchronous reset while word 4 is presented
        send_word(SYNC, 2'b11, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_word(16'($urandom), 2'b11, 1'b0, 0);
        check("busy_mid", 88'(frame_busy), 88'(1));
        @(negedge clk);
        ui_dout = 16'($urandom);
        ui_dout_be = 2'b11;
        ui_dout_empty = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        ui_dout_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        exp_data = '0;
        send_frame(rand_words(), 2'b11, 1'b0, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("pulse_total", 88'(vcount), 88'(exp_vcount));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft_packet_deframer.md
Name: ft_packet_deframer

Overview:
Host-to-FPGA counterpart of the telemetry-to-FT serializer. It drains 16-bit words from the FT bridge receive FIFO (ui_dout side) and hunts for a sync word. It reassembles the following six words into one 88-bit telemetry packet, using the same word order the FPGA-to-host path emits. Packets go to a downstream consumer (telemetry checker / loopback injector) as a one-cycle valid pulse, and the block keeps packet and error counters for LED/debug use.

Parameters:
SYNC_WORD, 16'hA55A, frame start marker
TIMEOUT_CYCLES, 1024, max idle cycles between words inside a frame before abort
CNT_W, 16, width of pkt_count and err_count

Ports:
clk  in  1  system clock (clk_128M domain); one clock, no CDC inside
rst_n  in  1  asynchronous active-low reset
ui_dout  in  16  FT receive FIFO data, first-word-fall-through
ui_dout_be  in  2  byte enables for ui_dout
ui_dout_empty  in  1  FIFO empty
ui_dout_get  out  1  pop strobe; word consumed when get && !empty
clear_counters  in  1  synchronous clear of pkt_count / err_count
packet_data  out  88  assembled packet, held until next packet completes
packet_valid  out  1  one-cycle pulse, packet_data valid
pkt_count  out  CNT_W  good packets, wraps
err_count  out  CNT_W  framing/timeout/checksum errors, saturates at all-ones
frame_busy  out  1  high while a frame is partially received

Behaviour:
- Reset is asynchronous on rst_n low. While reset is asserted: state HUNT, all outputs 0, packet_data 0, timeout counter 0. Any partial frame is discarded and not counted.
- ui_dout_get is 1 in HUNT and DATA, and 0 in EMIT. A word is accepted only when get && !empty.
- HUNT:
  - Accepted word == SYNC_WORD with be==2'b11 -> DATA, idx=0.
  - All other words are discarded silently; no error is counted.
- DATA, idx 0..5: word idx maps to packet bits [16*idx+15:16*idx].
  - Word 5 maps to bits [87:80] from ui_dout[7:0]. ui_dout[15:8] is ignored, and be of 2'b01 or 2'b11 is allowed.
  - Words 0..4 require be==2'b11. Any other be -> err_count+1, go to HUNT.
  - SYNC_WORD inside DATA is treated as data; there is no escaping.
- Timeout: a counter resets on every accepted word and increments each cycle in DATA without an accepted word. Reaching TIMEOUT_CYCLES -> err_count+1, go to HUNT.
- Completion: after word 5 is accepted (or the checksum word when enabled), go to EMIT for exactly one cycle.
  - In EMIT: packet_data is updated from the shadow register and packet_valid=1.
  - pkt_count+1 on the same cycle.
  - Latency: packet_valid is high one cycle after the last word's get&&!empty cycle.
  - Next state is HUNT.
- packet_data only changes in EMIT. Aborted frames never disturb it.
- frame_busy = (state==DATA).
- Counters:
  - clear_counters has priority over a simultaneous increment; the result is 0.
  - pkt_count wraps modulo 2^CNT_W.
  - err_count holds at 2^CNT_W-1.
- There is no downstream backpressure. The consumer must accept the pulse.

Optional Feature:
Macro FT_DEFRAME_CHECKSUM_EN.
- Defined: a 7th word follows word 5. It must equal the XOR of words 0..5, with word 5's high byte forced to 0, and must have be==2'b11.
  - Match -> EMIT.
  - Mismatch -> err_count+1, go to HUNT, no packet_valid.
  - Timeout rules apply to this word too.
- Undefined: the frame ends at word 5 and no checksum logic is present.

Decomposition:
- Package ft_packet_pkg holds:
  - PKT_W=88
  - WORDS_PER_PKT=6
  - the default SYNC_WORD
  - the state enum {HUNT, DATA, EMIT}
  - the word-to-bit-slice mapping function
- The FPGA-to-host serializer shares the same package.
- One sub-module, sat_counter (width param, inc, clr, saturate-vs-wrap param), is instantiated for both counters.

Test Plan:
1. Sync frame: A55A, 1111, 2222, 3333, 4444, 5555, 0066 (be 11) -> packet_valid once, packet_data=88'h66_5555_4444_3333_2222_1111, pkt_count=1, latency 1 cycle after last pop.
2. Garbage 0000, BEEF, then a valid frame -> garbage ignored, err_count=0, one correct packet.
3. Word 2 with be=2'b10 -> err_count=1, no packet_valid; the next valid frame decodes correctly.
4. Empty held high for 1024 cycles after word 3 -> err_count=1, frame_busy falls. A frame afterwards decodes.
5. rst_n pulsed low mid-frame, during word 4 -> outputs 0 immediately (asynchronous), counters 0, clean recovery on the next frame.
6. With FT_DEFRAME_CHECKSUM_EN, frame 1 plus checksum 0066^1111^2222^3333^4444^5555 -> packet emitted. Checksum off by one bit -> err_count+1, no packet. Simultaneous clear_counters and increment -> counters read 0.
